// File: rtl/token_err_pkg.sv
// ============================================================================
// Module  : token_err_pkg
// Brief   : Shared types and constants for the token error scheduler:
//           FSM state encoding, dual-rail error codes, delay-counter width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package token_err_pkg;

  // Width of the shared EVAL/EXTEND down-counter (covers delays 1..15)
  localparam int DLY_CNT_W = 4;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_EVAL   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EXTEND = 3'd4,
    ST_SEND   = 3'd5,
    ST_RTZ    = 3'd6
  } state_t;

  // Dual-rail error detector codes, ordered {Err1, Err0}
  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_OK   = 2'b01;
  localparam logic [1:0] RAIL_ERR  = 2'b10;
  localparam logic [1:0] RAIL_ILL  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/err_sat_counter.sv
// ============================================================================
// Module  : err_sat_counter
// Brief   : CNT_W-bit saturating incrementer with synchronous clear. Holds at
//           all-ones once reached.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module err_sat_counter
  import token_err_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increment requests, stopping at the maximum value
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/token_err_sched.sv
// ============================================================================
// Module  : token_err_sched
// Brief   : Clocked sequencer for one timing-resilient pipeline stage. Accepts
//           a token on a 4-phase left handshake, pulses latch_en, waits
//           DELAY_CYC cycles, samples the dual-rail error detector, adds
//           EXTRA_CYC recovery cycles on error, then releases the token on a
//           4-phase right handshake.
//           Optional feature macro: ERR_STATS_EN adds the err_count port and
//           its saturating counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module token_err_sched
  import token_err_pkg::*;
#(
  parameter int DELAY_CYC = 4,
  parameter int EXTRA_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Lreq,
  output logic             Lack,
  output logic             Rreq,
  input  logic             Rack,
  output logic             latch_en,
  output logic             sample,
  input  logic             Err1,
  input  logic             Err0,
  output logic             timing_err,
  output logic             protocol_err,
  output logic             busy
`ifdef ERR_STATS_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  // Counter load values; loads are one less than the cycle counts
  localparam logic [DLY_CNT_W-1:0] DLY_LOAD = DLY_CNT_W'(DELAY_CYC - 1);
  localparam logic [DLY_CNT_W-1:0] EXT_LOAD = DLY_CNT_W'(EXTRA_CYC - 1);

  // Reject out-of-range configurations at elaboration
  if ((DELAY_CYC < 1) || (DELAY_CYC > 15) || (EXTRA_CYC < 1) ||
      (EXTRA_CYC > 15) || (CNT_W < 1)) begin : g_param_check
    $error("token_err_sched: parameter out of legal range");
  end

  state_t               state;
  logic [DLY_CNT_W-1:0] cnt;
  logic [1:0]           rails;

  assign rails = {Err1, Err0};

  // Main sequencer: state, delay counter and all handshake/strobe outputs.
  // EVAL runs DELAY_CYC-1 cycles after LATCH so sample rises DELAY_CYC
  // cycles after latch_en; EXTEND runs the full EXTRA_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      Rreq         <= 1'b0;
      latch_en     <= 1'b0;
      sample       <= 1'b0;
      timing_err   <= 1'b0;
      protocol_err <= 1'b0;
      busy         <= 1'b0;
    end else begin
      latch_en   <= 1'b0;
      timing_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Lreq && !Lack) begin
            state    <= ST_LATCH;
            latch_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LATCH: begin
          cnt <= DLY_LOAD;
          if (DLY_LOAD == '0) begin
            state  <= ST_SAMPLE;
            sample <= 1'b1;
          end else begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          cnt <= cnt - DLY_CNT_W'(1);
          if (cnt == DLY_CNT_W'(1)) begin
            state  <= ST_SAMPLE;
            sample <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          case (rails)
            RAIL_OK: begin
              sample <= 1'b0;
              Rreq   <= 1'b1;
              state  <= ST_SEND;
            end
            RAIL_ERR, RAIL_ILL: begin
              sample     <= 1'b0;
              timing_err <= 1'b1;
              cnt        <= EXT_LOAD;
              state      <= ST_EXTEND;
              if (rails == RAIL_ILL) begin
                protocol_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_EXTEND: begin
          if (cnt == '0) begin
            state <= ST_SEND;
            Rreq  <= 1'b1;
          end else begin
            cnt <= cnt - DLY_CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (Rack) begin
            Rreq  <= 1'b0;
            state <= ST_RTZ;
          end
        end
        ST_RTZ: begin
          if (!Rack && (rails == RAIL_NULL)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Left acknowledge: raised on token acceptance, dropped once Lreq returns
  // to zero, independent of how far the token has progressed downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      Lack <= 1'b0;
    end else if ((state == ST_IDLE) && Lreq && !Lack) begin
      Lack <= 1'b1;
    end else if (Lack && !Lreq) begin
      Lack <= 1'b0;
    end
  end

`ifdef ERR_STATS_EN
  logic err_hit;

  // Count on the same edge that raises timing_err so both agree in a cycle
  assign err_hit = (state == ST_SAMPLE) && rails[1];

  err_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (err_hit),
    .count (err_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_token_err_sched.sv
// ============================================================================
// Module  : tb_token_err_sched
// Brief   : Randomised scoreboard bench for token_err_sched. The driver acts
//           as the left/right environment and, from the timing rules alone,
//           queues the cycle at which each output event must appear; a
//           negedge monitor matches observed events against that queue.
//           Honours ERR_STATS_EN for the err_count port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_token_err_sched;

  localparam int D    = 4;
  localparam int E    = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int EV_LATCH  = 0;
  localparam int EV_LACK_R = 1;
  localparam int EV_LACK_F = 2;
  localparam int EV_S_R    = 3;
  localparam int EV_S_F    = 4;
  localparam int EV_TERR   = 5;
  localparam int EV_R_R    = 6;
  localparam int EV_R_F    = 7;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic Lreq = 1'b0;
  logic Rack = 1'b0;
  logic Err1 = 1'b0;
  logic Err0 = 1'b0;
  logic Lack, Rreq, latch_en, sample, timing_err, protocol_err, busy;
`ifdef ERR_STATS_EN
  logic [CW-1:0] err_count;
`endif

  typedef struct {
    int ev;
    int cyc;
    int val;
  } exp_t;

  exp_t q[$];
  int   edge_n    = 0;
  int   errors    = 0;
  int   checks    = 0;
  int   cnt_model = 0;
  int   prot_set  = -1;
  int   prot_clr  = -1;
  bit   mon_en    = 1'b0;
  logic p_lack = 1'b0, p_sample = 1'b0, p_rreq = 1'b0;

  token_err_sched #(
    .DELAY_CYC (D),
    .EXTRA_CYC (E),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Lreq         (Lreq),
    .Lack         (Lack),
    .Rreq         (Rreq),
    .Rack         (Rack),
    .latch_en     (latch_en),
    .sample       (sample),
    .Err1         (Err1),
    .Err0         (Err0),
    .timing_err   (timing_err),
    .protocol_err (protocol_err),
    .busy         (busy)
`ifdef ERR_STATS_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string ev_str(input int ev);
    case (ev)
      EV_LATCH:  return "latch_en";
      EV_LACK_R: return "Lack_rise";
      EV_LACK_F: return "Lack_fall";
      EV_S_R:    return "sample_rise";
      EV_S_F:    return "sample_fall";
      EV_TERR:   return "timing_err";
      EV_R_R:    return "Rreq_rise";
      default:   return "Rreq_fall";
    endcase
  endfunction

  // Sticky protocol_err as the rules define it: set by an illegal code,
  // cleared only by reset
  function automatic bit prot_exp(input int c);
    if (prot_set < 0 || c < prot_set) return 1'b0;
    if (prot_clr >= prot_set && c >= prot_clr) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int ev, input int cyc, input int val = 0);
    exp_t x;
    x.ev  = ev;
    x.cyc = cyc;
    x.val = val;
    q.push_back(x);
  endtask

  task automatic observe(input int ev, input int cyc);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].ev == ev) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s: seen in cycle %0d, none expected", ev_str(ev), cyc);
    end else begin
      if (q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL %s_cycle: got cycle %0d, expected cycle %0d", ev_str(ev), cyc, q[idx].cyc);
      end
`ifdef ERR_STATS_EN
      if (ev == EV_TERR) check("err_count", int'(err_count), q[idx].val);
`endif
      q.delete(idx);
    end
  endtask

  // Monitor: detect output events and reconcile them with the scoreboard
  always @(negedge clk) begin : mon
    int cyc;
    cyc = edge_n + 1;
    if (mon_en) begin
      if (latch_en)              observe(EV_LATCH, cyc);
      if (Lack && !p_lack)       observe(EV_LACK_R, cyc);
      if (!Lack && p_lack)       observe(EV_LACK_F, cyc);
      if (sample && !p_sample)   observe(EV_S_R, cyc);
      if (!sample && p_sample)   observe(EV_S_F, cyc);
      if (timing_err)            observe(EV_TERR, cyc);
      if (Rreq && !p_rreq)       observe(EV_R_R, cyc);
      if (!Rreq && p_rreq)       observe(EV_R_F, cyc);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_%s: expected in cycle %0d, absent", ev_str(q[i].ev), q[i].cyc);
          q.delete(i);
        end
      end
      check("protocol_err", int'(protocol_err), int'(prot_exp(cyc)));
    end
    p_lack   = Lack;
    p_sample = sample;
    p_rreq   = Rreq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [7:0] v;
    v = {1'b0, Lack, Rreq, latch_en, sample, timing_err, protocol_err, busy};
`ifdef ERR_STATS_EN
    v[7] = (err_count != '0);
`endif
    check(name, int'(v), 0);
  endtask

  // One token through the stage.
  // kind: 0 rails 01, 1 rails 10, 2 rails 11. swait: SAMPLE edges before the
  // rails become valid. rwait: SEND edges before Rack. zwait: extra RTZ edges
  // with Rack still high. hold: keep Lreq high past the token. noise: random
  // rails/Rack while the stage is evaluating.
  task automatic token(input int kind, input int swait, input int rwait,
                       input int zwait, input bit hold, input bit noise);
    int e, m, r, k, j, x;
    Lreq = 1'b1;
    e = edge_n + 1;
    push(EV_LATCH, e + 1);
    push(EV_LACK_R, e + 1);
    push(EV_S_R, e + 1 + D);
    if (!hold) push(EV_LACK_F, e + 2);
    step();
    if (!hold) Lreq = 1'b0;
    for (int i = 1; i <= D; i++) begin
      if (noise) begin
        {Err1, Err0} = 2'($urandom_range(0, 3));
        Rack = 1'($urandom_range(0, 1));
      end
      step();
    end
    {Err1, Err0} = 2'b00;
    Rack = 1'b0;
    repeat (swait) step();
    m = edge_n + 1;
    if (kind == 0) begin
      Err1 = 1'b0;
      Err0 = 1'b1;
      r = m + 1;
    end else begin
      Err1 = 1'b1;
      Err0 = (kind == 2);
      cnt_model = (cnt_model < CMAX) ? cnt_model + 1 : CMAX;
      push(EV_TERR, m + 1, cnt_model);
      r = m + 1 + E;
      if (kind == 2 && !prot_exp(m + 1)) prot_set = m + 1;
    end
    push(EV_S_F, m + 1);
    push(EV_R_R, r);
    step();
    {Err1, Err0} = 2'b00;
    check("busy_in_flight", int'(busy), 1);
    while (edge_n + 1 < r + rwait) step();
    Rack = 1'b1;
    k = edge_n + 1;
    push(EV_R_F, k + 1);
    step();
    repeat (zwait) step();
    Rack = 1'b0;
    j = edge_n + 1;
    step();
    check("busy_idle", int'(busy), 0);
    if (hold) begin
      repeat ($urandom_range(0, 2)) step();
      Lreq = 1'b0;
      x = edge_n + 1;
      push(EV_LACK_F, x + 1);
      step();
    end
    if (j < 0) $display("unreachable");
  endtask

  // Token interrupted by reset on its second SAMPLE edge
  task automatic reset_mid();
    int e, rs;
    Lreq = 1'b1;
    e = edge_n + 1;
    push(EV_LATCH, e + 1);
    push(EV_LACK_R, e + 1);
    push(EV_S_R, e + 1 + D);
    push(EV_LACK_F, e + 2);
    step();
    Lreq = 1'b0;
    repeat (D + 1) step();
    rst = 1'b1;
    rs = edge_n + 1;
    push(EV_S_F, rs + 1);
    prot_clr  = rs + 1;
    cnt_model = 0;
    step();
    check_all_zero("reset_mid_outputs");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed: no error, error, illegal rails, held Lreq, short token
    token(0, 2, 2, 0, 1'b0, 1'b0);
    token(1, 2, 0, 0, 1'b0, 1'b1);
    token(2, 2, 1, 1, 1'b0, 1'b1);
    token(0, 0, 0, 0, 1'b1, 1'b0);
    token(0, 1, 0, 0, 1'b0, 1'b0);

    // Reset in SAMPLE, then a clean token
    reset_mid();
    token(0, 2, 2, 0, 1'b0, 1'b0);

    // Saturation: five error tokens from a cleared count
    repeat (5) token(1, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);

    // Random traffic
    repeat (30) begin
      int kd, kind;
      repeat ($urandom_range(0, 2)) step();
      kd = $urandom_range(0, 9);
      kind = (kd < 6) ? 0 : ((kd < 9) ? 1 : 2);
      token(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (D + E + 6) step();
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
